sram_bist_ctrl: RTL and testbench
=================================

# sram_bist_ctrl

March C- built-in self-test controller for the 1024x32 single-port SRAM macros in `chip_core`. It sits directly upstream of a macro's BIST port. It drives the `A_BIST_*` control, address and data inputs and checks the macro's `A_DOUT` read data. It reports pass/fail status, the number of failing reads, and the first failing address and syndrome. One instance serves one macro.

## Interface
Parameters:
- `ADDR_W`, 10, address width; words tested N = 2^ADDR_W
- `DATA_W`, 32, word width
- `CNT_W`, 16, width of the fail counter

Ports:
- `clk`  in  1  clock; also tied to the macro's `A_BIST_CLK` at integration
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request a test run; level sampled each cycle
- `busy`  out  1  test in progress
- `done`  out  1  sticky run-complete flag; cleared by the next accepted `start`
- `pass`  out  1  valid when `done`=1; equals (`fail_count`==0)
- `fail_count`  out  CNT_W  failing reads; saturates at all-ones
- `fail_addr`  out  ADDR_W  address of the first failing read
- `fail_syndrome`  out  DATA_W  (read data XOR expected) of the first failing read
- `bist_en`  out  1  to `A_BIST_EN`
- `bist_men`  out  1  to `A_BIST_MEN`
- `bist_wen`  out  1  to `A_BIST_WEN`
- `bist_ren`  out  1  to `A_BIST_REN`
- `bist_addr`  out  ADDR_W  to `A_BIST_ADDR`
- `bist_din`  out  DATA_W  to `A_BIST_DIN`
- `bist_bm`  out  DATA_W  to `A_BIST_BM`
- `bist_dout`  in  DATA_W  from `A_DOUT`

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE → RUN on `start`=1.
  - RUN → DRAIN after the last operation is issued.
  - DRAIN → DONE after one cycle.
  - `start` is ignored in RUN and DRAIN.
- **Passes:** two, with background B = 0x00000000 in pass 0 and 0x55555555 in pass 1. Data "0" = B, data "1" = ~B, both at DATA_W width.
- **March elements per pass** (↑ = address 0..N-1, ↓ = N-1..0):
  - M0 ↑w0
  - M1 ↑(r0,w1)
  - M2 ↑(r1,w0)
  - M3 ↓(r0,w1)
  - M4 ↓(r1,w0)
  - M5 ↑r0
- Each read and each write occupies one cycle. A pass is 10N cycles; a run is 20N cycles.
- **BIST port outputs** (all registered):
  - `bist_en`=1 throughout RUN and DRAIN.
  - `bist_men`=1 only in cycles that issue an operation.
  - Writes: `bist_wen`=1, `bist_ren`=0. Reads: `bist_ren`=1, `bist_wen`=0. Never both.
  - `bist_bm` = all-ones whenever `bist_en`=1, else 0.
  - `bist_din` = the write data during writes, 0 otherwise.
- **Read check:**
  - Each issued read registers its expected data and address alongside it.
  - The compare occurs the following cycle against `bist_dout`.
  - On mismatch: `fail_count` increments, saturating at all-ones.
  - On the first mismatch of a run only: `fail_addr` and `fail_syndrome` capture.
- **Accepted `start`:** clears `done`, `fail_count`, `fail_addr`, `fail_syndrome`.
- **`done`:** stays 1 in DONE until the next accepted `start`.
- **Reset values:** all outputs 0, state IDLE.
- **Reset mid-run:** asynchronous; `bist_en`/`men`/`wen`/`ren` drop immediately and the status is lost.

## Timing
- `start` sampled high at the edge ending cycle T. Then:
  - `busy`=1 from cycle T+1.
  - The first operation (w0, addr 0, din B) is presented in cycle T+1.
- Operations occupy cycles T+1 .. T+20N. The last one is the M5 read at address N-1 of pass 1.
- Read data is valid on `bist_dout` in the cycle after the read is presented (synchronous macro read).
- DRAIN occupies cycle T+20N+1 and compares the final read.
- `done`=1, `busy`=0 and final status are visible from cycle T+20N+2.
- Defaults (N=1024): `done` rises at T+20482.
- Status outputs update only on compare edges and at start acceptance.

## Test plan
- **Fault-free memory model, ADDR_W=4:**
  - `start` pulse at T → `busy` in cycles T+1..T+321.
  - `done`=1 at T+322, `pass`=1, `fail_count`=0.
  - Port sequence matches the March C- order exactly, with `bist_wen` and `bist_ren` never both high.
- **Stuck-at-1, bit 7 of address 0x155, default parameters:**
  - `done` at T+20482, `pass`=0, `fail_count`=6.
  - `fail_addr`=0x155, `fail_syndrome`=0x00000080.
- **Stuck-at-0, bit 0 of address 0x3FF:**
  - `fail_count`=5 (pass 0: M2 and M4 reads; pass 1: M1, M3 and M5 reads, since bit 0 of 0x55555555 is 1).
  - `fail_addr`=0x3FF, `fail_syndrome`=0x00000001.
- **`start` held high through a run:**
  - No restart while busy.
  - A second run begins the cycle after `done` rises, and `done` clears on that acceptance.
- **`rst_n` asserted at cycle T+5000 of a run:**
  - All outputs are 0 asynchronously.
  - After release and a new `start`, a full clean run passes.
- **Fail counter saturation, CNT_W=4, every word returning all-ones:**
  - `fail_count`=15, `pass`=0.
  - `fail_addr`=0, `fail_syndrome`=0xFFFFFFFF (the first M1 r0 read, expecting 0).

Source files
------------

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller for a single-port SRAM macro: two background passes,
// registered BIST port drive, one-cycle-late read compare and first-fail capture.
module sram_bist_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_syndrome,
  output logic              bist_en,
  output logic              bist_men,
  output logic              bist_wen,
  output logic              bist_ren,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [DATA_W-1:0] bist_din,
  output logic [DATA_W-1:0] bist_bm,
  input  logic [DATA_W-1:0] bist_dout
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;

  state_t              state_q, state_d;
  logic                pass_q, pass_d;
  elem_t               elem_q, elem_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                phase_q, phase_d;
  logic                last_q;

  logic                accept, issue;
  logic                cur_pass, cur_phase;
  elem_t               cur_elem;
  logic [ADDR_W-1:0]   cur_idx;
  logic                cur_last;
  logic                op_wr, op_one, two_op, down;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_data, bg;

  // read-check pipeline: stage 1 rides with the presented read, stage 2 meets bist_dout
  logic [DATA_W-1:0]   exp1_q, exp2_q;
  logic [ADDR_W-1:0]   addr2_q;
  logic                rd2_q;
  logic [DATA_W-1:0]   syndrome;

  function automatic logic [DATA_W-1:0] background(input logic p);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < DATA_W; i++) b[i] = p & (i % 2 == 0);
    return b;
  endfunction

  always_comb begin
    accept    = (state_q == IDLE || state_q == DONE) && start;
    issue     = accept || (state_q == RUN && !last_q);
    cur_pass  = accept ? 1'b0 : pass_q;
    cur_elem  = accept ? M0   : elem_q;
    cur_idx   = accept ? '0   : idx_q;
    cur_phase = accept ? 1'b0 : phase_q;

    bg     = background(cur_pass);
    two_op = (cur_elem != M0) && (cur_elem != M5);
    down   = (cur_elem == M3) || (cur_elem == M4);
    op_wr  = 1'b0;
    op_one = 1'b0;
    case (cur_elem)
      M0:      op_wr = 1'b1;
      M1, M3:  begin op_wr = cur_phase; op_one = cur_phase;  end
      M2, M4:  begin op_wr = cur_phase; op_one = ~cur_phase; end
      default: op_wr = 1'b0;
    endcase
    op_addr  = down ? ~cur_idx : cur_idx;
    op_data  = op_one ? ~bg : bg;
    cur_last = cur_pass && (cur_elem == M5) && (&cur_idx);

    pass_d  = cur_pass;
    elem_d  = cur_elem;
    idx_d   = cur_idx;
    phase_d = 1'b0;
    if (two_op && !cur_phase) begin
      phase_d = 1'b1;
    end else if (&cur_idx) begin
      idx_d = '0;
      if (cur_elem == M5) begin
        elem_d = M0;
        pass_d = ~cur_pass;
      end else begin
        elem_d = elem_t'(cur_elem + 3'd1);
      end
    end else begin
      idx_d = cur_idx + 1'b1;
    end

    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (last_q) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase

    syndrome = bist_dout ^ exp2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pass_q  <= 1'b0;
      elem_q  <= M0;
      idx_q   <= '0;
      phase_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        pass_q  <= pass_d;
        elem_q  <= elem_d;
        idx_q   <= idx_d;
        phase_q <= phase_d;
        last_q  <= cur_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bist_en   <= 1'b0;
      bist_men  <= 1'b0;
      bist_wen  <= 1'b0;
      bist_ren  <= 1'b0;
      bist_addr <= '0;
      bist_din  <= '0;
      bist_bm   <= '0;
      exp1_q    <= '0;
      exp2_q    <= '0;
      addr2_q   <= '0;
      rd2_q     <= 1'b0;
    end else begin
      bist_en   <= (state_d == RUN) || (state_d == DRAIN);
      bist_men  <= issue;
      bist_wen  <= issue && op_wr;
      bist_ren  <= issue && !op_wr;
      bist_addr <= issue ? op_addr : '0;
      bist_din  <= (issue && op_wr) ? op_data : '0;
      bist_bm   <= ((state_d == RUN) || (state_d == DRAIN)) ? '1 : '0;
      exp1_q    <= (issue && !op_wr) ? op_data : '0;
      exp2_q    <= exp1_q;
      addr2_q   <= bist_addr;
      rd2_q     <= bist_ren;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_count    <= '0;
      fail_addr     <= '0;
      fail_syndrome <= '0;
    end else if (accept) begin
      fail_count    <= '0;
      fail_addr     <= '0;
      fail_syndrome <= '0;
    end else if (rd2_q && (syndrome != '0)) begin
      if (fail_count != '1) fail_count <= fail_count + 1'b1;
      if (fail_count == '0) begin
        fail_addr     <= addr2_q;
        fail_syndrome <= syndrome;
      end
    end
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = done && (fail_count == '0);

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl: small fault-free run with full port-sequence
// check, default-size stuck-at runs, mid-run reset, start held high, counter saturation.
module tb_sram_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: ADDR_W=4, fault-free ----------------
  logic        start_a, busy_a, done_a, pass_a, en_a, men_a, wen_a, ren_a;
  logic [15:0] fcnt_a;
  logic [3:0]  faddr_a, addr_a;
  logic [31:0] fsyn_a, din_a, bm_a, dout_a;
  logic [31:0] mem_a [16];

  sram_bist_ctrl #(.ADDR_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fcnt_a), .fail_addr(faddr_a), .fail_syndrome(fsyn_a),
    .bist_en(en_a), .bist_men(men_a), .bist_wen(wen_a), .bist_ren(ren_a),
    .bist_addr(addr_a), .bist_din(din_a), .bist_bm(bm_a), .bist_dout(dout_a));

  always @(posedge clk) begin
    if (men_a && wen_a) mem_a[addr_a] <= din_a;
    if (men_a && ren_a) dout_a <= mem_a[addr_a];
  end

  // ---------------- instance B: default size, injectable stuck-at ----------------
  logic        start_b, busy_b, done_b, pass_b, en_b, men_b, wen_b, ren_b;
  logic [15:0] fcnt_b;
  logic [9:0]  faddr_b, addr_b, flt_addr;
  logic [31:0] fsyn_b, din_b, bm_b, dout_b, sa1, sa0, rd_b;
  logic [31:0] mem_b [1024];

  sram_bist_ctrl u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fcnt_b), .fail_addr(faddr_b), .fail_syndrome(fsyn_b),
    .bist_en(en_b), .bist_men(men_b), .bist_wen(wen_b), .bist_ren(ren_b),
    .bist_addr(addr_b), .bist_din(din_b), .bist_bm(bm_b), .bist_dout(dout_b));

  always @(posedge clk) begin
    if (men_b && wen_b) mem_b[addr_b] <= din_b;
    if (men_b && ren_b) begin
      rd_b = mem_b[addr_b];
      if (addr_b == flt_addr) rd_b = (rd_b | sa1) & ~sa0;
      dout_b <= rd_b;
    end
  end

  // ---------------- instance C: ADDR_W=4, CNT_W=4, memory reads all-ones ----------------
  logic        start_c, busy_c, done_c, pass_c, en_c, men_c, wen_c, ren_c;
  logic [3:0]  fcnt_c, faddr_c, addr_c;
  logic [31:0] fsyn_c, din_c, bm_c;
  logic [31:0] dout_c = 32'hFFFF_FFFF;

  sram_bist_ctrl #(.ADDR_W(4), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .fail_count(fcnt_c), .fail_addr(faddr_c), .fail_syndrome(fsyn_c),
    .bist_en(en_c), .bist_men(men_c), .bist_wen(wen_c), .bist_ren(ren_c),
    .bist_addr(addr_c), .bist_din(din_c), .bist_bm(bm_c), .bist_dout(dout_c));

  // ---------------- expected March C- sequence for N=16 ----------------
  logic [37:0] exp_ops [320];  // {wen, ren, addr, din}

  task automatic build_ops();
    int k = 0;
    logic [31:0] b;
    for (int p = 0; p < 2; p++) begin
      b = (p == 0) ? 32'h0000_0000 : 32'h5555_5555;
      for (int a = 0; a < 16; a++) begin exp_ops[k] = {2'b10, 4'(a), b}; k++; end
      for (int a = 0; a < 16; a++) begin
        exp_ops[k] = {2'b01, 4'(a), 32'h0}; k++;
        exp_ops[k] = {2'b10, 4'(a), ~b};    k++;
      end
      for (int a = 0; a < 16; a++) begin
        exp_ops[k] = {2'b01, 4'(a), 32'h0}; k++;
        exp_ops[k] = {2'b10, 4'(a), b};     k++;
      end
      for (int a = 15; a >= 0; a--) begin
        exp_ops[k] = {2'b01, 4'(a), 32'h0}; k++;
        exp_ops[k] = {2'b10, 4'(a), ~b};    k++;
      end
      for (int a = 15; a >= 0; a--) begin
        exp_ops[k] = {2'b01, 4'(a), 32'h0}; k++;
        exp_ops[k] = {2'b10, 4'(a), b};     k++;
      end
      for (int a = 0; a < 16; a++) begin exp_ops[k] = {2'b01, 4'(a), 32'h0}; k++; end
    end
  endtask

  // Called at the negedge of cycle T with start_a already high.
  task automatic run_a(input string tag, input bit hold);
    @(negedge clk);
    if (!hold) start_a = 1'b0;
    for (int k = 0; k < 320; k++) begin
      check($sformatf("%s_op%0d", tag, k),
            64'({en_a, men_a, wen_a, ren_a, addr_a, din_a, busy_a, done_a}),
            64'({2'b11, exp_ops[k], 2'b10}));
      @(negedge clk);
    end
    check({tag, "_drain"}, 64'({busy_a, done_a, en_a, men_a, wen_a, ren_a, bm_a}),
          64'({6'b101000, 32'hFFFF_FFFF}));
    @(negedge clk);
    check({tag, "_done"}, 64'({busy_a, done_a, pass_a, en_a, men_a, bm_a}), 64'({5'b01100, 32'h0}));
    check({tag, "_cnt"}, 64'(fcnt_a), 64'(0));
  endtask

  task automatic run_b(input string tag, input logic [15:0] e_cnt, input logic [9:0] e_addr,
                       input logic [31:0] e_syn);
    int cyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1;
    while (!done_b && cyc < 21000) begin @(negedge clk); cyc++; end
    check({tag, "_latency"}, 64'(cyc), 64'(20482));
    check({tag, "_pass"}, 64'(pass_b), 64'(e_cnt == 0));
    check({tag, "_cnt"}, 64'(fcnt_b), 64'(e_cnt));
    check({tag, "_addr"}, 64'(faddr_b), 64'(e_addr));
    check({tag, "_syn"}, 64'(fsyn_b), 64'(e_syn));
  endtask

  initial begin
    int cyc;
    build_ops();
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    flt_addr = '0; sa1 = '0; sa0 = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl_a", 64'({busy_a, done_a, pass_a, en_a, men_a, wen_a, ren_a}), 64'(0));
    check("reset_data_a", 64'({fcnt_a, faddr_a, addr_a, din_a}), 64'(0));
    check("reset_bm_b", 64'({bm_b, fsyn_b}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_a", 64'({busy_a, done_a, en_a}), 64'(0));

    // fault-free run, then start held high across a second run, then restart on done
    start_a = 1'b1;
    run_a("a1", 1'b0);
    start_a = 1'b1;
    run_a("a2", 1'b1);
    run_a("a3", 1'b0);
    @(negedge clk);
    check("a_done_sticky", 64'({done_a, busy_a}), 64'(2'b10));

    // every read returns all-ones: counter saturates, first fail is M1 r0 at 0
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    cyc = 1;
    while (!done_c && cyc < 400) begin @(negedge clk); cyc++; end
    check("c_latency", 64'(cyc), 64'(322));
    check("c_cnt", 64'(fcnt_c), 64'(15));
    check("c_pass", 64'(pass_c), 64'(0));
    check("c_addr", 64'(faddr_c), 64'(0));
    check("c_syn", 64'(fsyn_c), 64'(32'hFFFF_FFFF));

    // stuck-at-1 bit 7 at 0x155
    flt_addr = 10'h155; sa1 = 32'h0000_0080; sa0 = '0;
    run_b("b_sa1", 16'd6, 10'h155, 32'h0000_0080);
    // stuck-at-0 bit 0 at 0x3FF
    flt_addr = 10'h3FF; sa1 = '0; sa0 = 32'h0000_0001;
    run_b("b_sa0", 16'd5, 10'h3FF, 32'h0000_0001);

    // reset at T+5000 of a fault-free run
    sa0 = '0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (4999) @(negedge clk);
    check("b_midrun", 64'({busy_b, en_b, men_b, bm_b}), 64'({3'b111, 32'hFFFF_FFFF}));
    rst_n = 1'b0;
    #1;
    check("b_rst_ctl", 64'({busy_b, done_b, pass_b, en_b, men_b, wen_b, ren_b}), 64'(0));
    check("b_rst_data", 64'({addr_b, din_b, fcnt_b}), 64'(0));
    check("b_rst_bm", 64'({bm_b, fsyn_b}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_b("b_clean", 16'd0, 10'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
